// File: rtl/urv_rf_write_arbiter.sv
// Register-file write-port arbiter: shares one write port between writeback, the
// long-latency unit and debug; tracks LU-pending registers and requests stalls on LU starvation.
module urv_rf_write_arbiter #(
   parameter int unsigned STARVE_MAX = 4,
   parameter bit          DBG_EN     = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_n_i,

   input  logic [4:0]  w_rd_i,
   input  logic [31:0] w_rd_value_i,
   input  logic        w_rd_store_i,

   input  logic        lu_valid_i,
   input  logic [4:0]  lu_rd_i,
   input  logic [31:0] lu_value_i,
   output logic        lu_ready_o,

   input  logic        dbg_valid_i,
   input  logic [4:0]  dbg_rd_i,
   input  logic [31:0] dbg_value_i,
   output logic        dbg_ready_o,

   input  logic        iss_valid_i,
   input  logic [4:0]  iss_rd_i,

   input  logic        d_check_i,
   input  logic [4:0]  d_rs1_i,
   input  logic [4:0]  d_rs2_i,
   input  logic [4:0]  d_rd_i,
   output logic        d_hazard_o,

   output logic        stall_req_o,

   output logic [4:0]  rf_rd_o,
   output logic [31:0] rf_rd_value_o,
   output logic        rf_rd_store_o
);

   localparam int unsigned NREG  = 32;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned RW    = 5;
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   // Round-robin pointer: which of LU/DBG wins the next contested cycle
   typedef enum logic {
      RR_LU  = 1'b0,
      RR_DBG = 1'b1
   } rr_e;

   rr_e              rr_q, rr_d;
   logic [NREG-1:0]  pending_q, pending_d;
   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   logic             stall_q, stall_d;

   logic             dbg_req;
   logic             lu_gnt;
   logic             dbg_gnt;

   // Grant selection: W always wins, then LU if starving, else round-robin
   always_comb begin
      dbg_req = DBG_EN && dbg_valid_i;
      lu_gnt  = 1'b0;
      dbg_gnt = 1'b0;
      if (!w_rd_store_i) begin
         if (stall_q) begin
            lu_gnt = lu_valid_i;
         end else if (lu_valid_i && dbg_req) begin
            if (rr_q == RR_LU) lu_gnt  = 1'b1;
            else               dbg_gnt = 1'b1;
         end else begin
            lu_gnt  = lu_valid_i;
            dbg_gnt = dbg_req;
         end
      end
   end

   assign lu_ready_o  = lu_gnt;
   assign dbg_ready_o = dbg_gnt;

   // Write port mux; idle port drives zeros
   always_comb begin
      rf_rd_store_o = w_rd_store_i | lu_gnt | dbg_gnt;
      rf_rd_o       = RW'(0);
      rf_rd_value_o = XLEN'(0);
      if (w_rd_store_i) begin
         rf_rd_o       = w_rd_i;
         rf_rd_value_o = w_rd_value_i;
      end else if (lu_gnt) begin
         rf_rd_o       = lu_rd_i;
         rf_rd_value_o = lu_value_i;
      end else if (dbg_gnt) begin
         rf_rd_o       = dbg_rd_i;
         rf_rd_value_o = dbg_value_i;
      end
   end

   // Next-state: scoreboard (set beats clear), starvation counter, RR pointer
   always_comb begin
      pending_d    = pending_q;
      starve_cnt_d = starve_cnt_q;
      rr_d         = rr_q;

      if (lu_gnt)
         pending_d[lu_rd_i] = 1'b0;
      if (iss_valid_i && (iss_rd_i != RW'(0)))
         pending_d[iss_rd_i] = 1'b1;
      pending_d[0] = 1'b0;

      if (!lu_valid_i || lu_gnt)
         starve_cnt_d = CNT_W'(0);
      else if (starve_cnt_q != CNT_MAX)
         starve_cnt_d = starve_cnt_q + CNT_W'(1);

      if (lu_gnt)
         rr_d = RR_DBG;
      else if (dbg_gnt)
         rr_d = RR_LU;
   end

   assign stall_d = (starve_cnt_d == CNT_MAX);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pending_q    <= '0;
         starve_cnt_q <= '0;
         stall_q      <= 1'b0;
         rr_q         <= RR_LU;
      end else begin
         pending_q    <= pending_d;
         starve_cnt_q <= starve_cnt_d;
         stall_q      <= stall_d;
         rr_q         <= rr_d;
      end
   end

   assign stall_req_o = stall_q;
   assign d_hazard_o  = d_check_i &
                        (pending_q[d_rs1_i] | pending_q[d_rs2_i] | pending_q[d_rd_i]);

   // Protocol checks; re-issue to a register completing in the same cycle is legal,
   // and x0 results are never tracked so they never count as unexpected.
   always_ff @(posedge clk_i) begin
      if (rst_n_i) begin
         assert (!(iss_valid_i && (iss_rd_i != RW'(0)) && pending_q[iss_rd_i] &&
                   !(lu_gnt && (lu_rd_i == iss_rd_i))))
            else $error("issue to already-pending rd %0d", iss_rd_i);
         assert (!(lu_gnt && (lu_rd_i != RW'(0)) && !pending_q[lu_rd_i]))
            else $error("LU completion for non-pending rd %0d", lu_rd_i);
      end
   end

endmodule

// File: tb/tb_urv_rf_write_arbiter.sv
// Directed bench for urv_rf_write_arbiter: arbitration, scoreboard, starvation, async reset.
module tb_urv_rf_write_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic [4:0]  w_rd_i;
   logic [31:0] w_rd_value_i;
   logic        w_rd_store_i;
   logic        lu_valid_i;
   logic [4:0]  lu_rd_i;
   logic [31:0] lu_value_i;
   logic        lu_ready_o;
   logic        dbg_valid_i;
   logic [4:0]  dbg_rd_i;
   logic [31:0] dbg_value_i;
   logic        dbg_ready_o;
   logic        iss_valid_i;
   logic [4:0]  iss_rd_i;
   logic        d_check_i;
   logic [4:0]  d_rs1_i;
   logic [4:0]  d_rs2_i;
   logic [4:0]  d_rd_i;
   logic        d_hazard_o;
   logic        stall_req_o;
   logic [4:0]  rf_rd_o;
   logic [31:0] rf_rd_value_o;
   logic        rf_rd_store_o;

   int vecs = 0;
   int errs = 0;

   always #5 clk_i = ~clk_i;

   urv_rf_write_arbiter #(.STARVE_MAX(4), .DBG_EN(1'b1)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .w_rd_i(w_rd_i), .w_rd_value_i(w_rd_value_i), .w_rd_store_i(w_rd_store_i),
      .lu_valid_i(lu_valid_i), .lu_rd_i(lu_rd_i), .lu_value_i(lu_value_i), .lu_ready_o(lu_ready_o),
      .dbg_valid_i(dbg_valid_i), .dbg_rd_i(dbg_rd_i), .dbg_value_i(dbg_value_i), .dbg_ready_o(dbg_ready_o),
      .iss_valid_i(iss_valid_i), .iss_rd_i(iss_rd_i),
      .d_check_i(d_check_i), .d_rs1_i(d_rs1_i), .d_rs2_i(d_rs2_i), .d_rd_i(d_rd_i),
      .d_hazard_o(d_hazard_o), .stall_req_o(stall_req_o),
      .rf_rd_o(rf_rd_o), .rf_rd_value_o(rf_rd_value_o), .rf_rd_store_o(rf_rd_store_o)
   );

   task automatic idle();
      w_rd_i = 5'd0; w_rd_value_i = 32'd0; w_rd_store_i = 1'b0;
      lu_valid_i = 1'b0; lu_rd_i = 5'd0; lu_value_i = 32'd0;
      dbg_valid_i = 1'b0; dbg_rd_i = 5'd0; dbg_value_i = 32'd0;
      iss_valid_i = 1'b0; iss_rd_i = 5'd0;
      d_check_i = 1'b0; d_rs1_i = 5'd0; d_rs2_i = 5'd0; d_rd_i = 5'd0;
   endtask

   // Advance to 1 time unit after the next rising edge
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst_n_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #3 rst_n_i = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      d_check_i = 1'b1; d_rs1_i = 5'd5; d_rs2_i = 5'd9; d_rd_i = 5'd31;
      #1;
      vecs++; if (d_hazard_o !== 1'b0) begin errs++; $display("FAIL reset_hazard got %b exp 0", d_hazard_o); end
      vecs++; if (stall_req_o !== 1'b0) begin errs++; $display("FAIL reset_stall got %b exp 0", stall_req_o); end
      vecs++; if (rf_rd_store_o !== 1'b0 || rf_rd_o !== 5'd0 || rf_rd_value_o !== 32'd0) begin
         errs++; $display("FAIL reset_port got st=%b rd=%0d v=%h exp 0/0/0", rf_rd_store_o, rf_rd_o, rf_rd_value_o); end
      idle();
   endtask

   task automatic test_lu_hazard();
      iss_valid_i = 1'b1; iss_rd_i = 5'd5;
      tick();
      iss_valid_i = 1'b0;
      d_check_i = 1'b1; d_rs1_i = 5'd5;
      lu_valid_i = 1'b1; lu_rd_i = 5'd5; lu_value_i = 32'hDEADBEEF;
      #1;
      vecs++; if (d_hazard_o !== 1'b1) begin errs++; $display("FAIL hazard_rs1 got %b exp 1", d_hazard_o); end
      vecs++; if (lu_ready_o !== 1'b1 || rf_rd_store_o !== 1'b1) begin
         errs++; $display("FAIL lu_grant got rdy=%b st=%b exp 1/1", lu_ready_o, rf_rd_store_o); end
      vecs++; if (rf_rd_o !== 5'd5 || rf_rd_value_o !== 32'hDEADBEEF) begin
         errs++; $display("FAIL lu_data got rd=%0d v=%h exp 5/deadbeef", rf_rd_o, rf_rd_value_o); end
      tick();
      lu_valid_i = 1'b0;
      #1;
      vecs++; if (d_hazard_o !== 1'b0) begin errs++; $display("FAIL hazard_clear got %b exp 0", d_hazard_o); end
      idle();
   endtask

   task automatic test_w_priority();
      iss_valid_i = 1'b1; iss_rd_i = 5'd7;
      tick();
      iss_valid_i = 1'b0;
      w_rd_store_i = 1'b1; w_rd_i = 5'd3; w_rd_value_i = 32'h11;
      lu_valid_i = 1'b1; lu_rd_i = 5'd7; lu_value_i = 32'h77;
      #1;
      vecs++; if (rf_rd_o !== 5'd3 || rf_rd_value_o !== 32'h11 || lu_ready_o !== 1'b0) begin
         errs++; $display("FAIL w_wins got rd=%0d v=%h lurdy=%b exp 3/11/0", rf_rd_o, rf_rd_value_o, lu_ready_o); end
      tick();
      w_rd_store_i = 1'b0;
      #1;
      vecs++; if (rf_rd_o !== 5'd7 || rf_rd_value_o !== 32'h77 || lu_ready_o !== 1'b1) begin
         errs++; $display("FAIL lu_after_w got rd=%0d v=%h lurdy=%b exp 7/77/1", rf_rd_o, rf_rd_value_o, lu_ready_o); end
      tick();
      idle();
   endtask

   task automatic test_round_robin();
      do_reset();
      lu_valid_i = 1'b1; lu_rd_i = 5'd0; lu_value_i = 32'hA;
      dbg_valid_i = 1'b1; dbg_rd_i = 5'd1; dbg_value_i = 32'hB;
      for (int i = 0; i < 4; i++) begin
         logic exp_lu;
         exp_lu = (i % 2) == 0;
         #1;
         vecs++; if (lu_ready_o !== exp_lu || dbg_ready_o !== !exp_lu) begin
            errs++; $display("FAIL rr_%0d got lu=%b dbg=%b exp lu=%b", i, lu_ready_o, dbg_ready_o, exp_lu); end
         vecs++; if (rf_rd_o !== (exp_lu ? 5'd0 : 5'd1) || rf_rd_value_o !== (exp_lu ? 32'hA : 32'hB)) begin
            errs++; $display("FAIL rr_data_%0d got rd=%0d v=%h", i, rf_rd_o, rf_rd_value_o); end
         tick();
      end
      idle();
   endtask

   task automatic test_starvation();
      do_reset();
      lu_valid_i = 1'b1; lu_rd_i = 5'd0; lu_value_i = 32'h44;
      w_rd_store_i = 1'b1; w_rd_i = 5'd2; w_rd_value_i = 32'h22;
      for (int i = 0; i < 4; i++) begin
         #1;
         vecs++; if (stall_req_o !== 1'b0 || lu_ready_o !== 1'b0) begin
            errs++; $display("FAIL starve_%0d got stall=%b lurdy=%b exp 0/0", i, stall_req_o, lu_ready_o); end
         tick();
      end
      #1;
      vecs++; if (stall_req_o !== 1'b1 || lu_ready_o !== 1'b0 || rf_rd_o !== 5'd2) begin
         errs++; $display("FAIL stall_w_wins got stall=%b lurdy=%b rd=%0d exp 1/0/2", stall_req_o, lu_ready_o, rf_rd_o); end
      tick();
      w_rd_store_i = 1'b0;
      dbg_valid_i = 1'b1; dbg_rd_i = 5'd8; dbg_value_i = 32'h88;
      #1;
      vecs++; if (stall_req_o !== 1'b1 || lu_ready_o !== 1'b1 || dbg_ready_o !== 1'b0 || rf_rd_value_o !== 32'h44) begin
         errs++; $display("FAIL stall_lu got stall=%b lu=%b dbg=%b v=%h exp 1/1/0/44", stall_req_o, lu_ready_o, dbg_ready_o, rf_rd_value_o); end
      tick();
      lu_valid_i = 1'b0;
      #1;
      vecs++; if (stall_req_o !== 1'b0 || dbg_ready_o !== 1'b1 || rf_rd_o !== 5'd8) begin
         errs++; $display("FAIL stall_drop got stall=%b dbg=%b rd=%0d exp 0/1/8", stall_req_o, dbg_ready_o, rf_rd_o); end
      tick();
      idle();
   endtask

   task automatic test_set_wins();
      do_reset();
      iss_valid_i = 1'b1; iss_rd_i = 5'd9;
      tick();
      lu_valid_i = 1'b1; lu_rd_i = 5'd9; lu_value_i = 32'h99;
      #1;
      vecs++; if (lu_ready_o !== 1'b1) begin errs++; $display("FAIL setclr_hs got %b exp 1", lu_ready_o); end
      tick();
      idle();
      d_check_i = 1'b1; d_rs2_i = 5'd9;
      #1;
      vecs++; if (d_hazard_o !== 1'b1) begin errs++; $display("FAIL set_wins got %b exp 1", d_hazard_o); end
      idle();
      iss_valid_i = 1'b1; iss_rd_i = 5'd0;
      tick();
      iss_valid_i = 1'b0;
      d_check_i = 1'b1; d_rs1_i = 5'd0;
      #1;
      vecs++; if (d_hazard_o !== 1'b0) begin errs++; $display("FAIL x0_hazard got %b exp 0", d_hazard_o); end
      idle();
   endtask

   task automatic test_async_reset();
      do_reset();
      iss_valid_i = 1'b1; iss_rd_i = 5'd4;
      tick();
      iss_valid_i = 1'b0;
      lu_valid_i = 1'b1; lu_rd_i = 5'd0;
      w_rd_store_i = 1'b1; w_rd_i = 5'd1;
      repeat (4) tick();
      d_check_i = 1'b1; d_rd_i = 5'd4;
      #1;
      vecs++; if (d_hazard_o !== 1'b1 || stall_req_o !== 1'b1) begin
         errs++; $display("FAIL pre_reset got haz=%b stall=%b exp 1/1", d_hazard_o, stall_req_o); end
      rst_n_i = 1'b0;
      #1;
      vecs++; if (d_hazard_o !== 1'b0 || stall_req_o !== 1'b0) begin
         errs++; $display("FAIL async_reset got haz=%b stall=%b exp 0/0", d_hazard_o, stall_req_o); end
      idle();
      tick();
      #2 rst_n_i = 1'b1;
      tick();
   endtask

   initial begin
      rst_n_i = 1'b0;
      idle();
      test_reset();
      test_lu_hazard();
      test_w_priority();
      test_round_robin();
      test_starvation();
      test_set_wins();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
